// File: rtl/clf_pkg.sv
// Shared types for the class vote filter: class index and vote FSM states.
package clf_pkg;

    localparam int NUM_CLASSES = 4;

    typedef logic [1:0] class_t;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        TRACK = 2'd1,
        HOLD  = 2'd2
    } vote_state_t;

endpackage

// File: rtl/vote_window.sv
// Sliding window of the last WINDOW class samples with per-class occupancy counters.
module vote_window
    import clf_pkg::*;
#(
    parameter int WINDOW = 8,
    localparam int CW = $clog2(WINDOW + 1)
)(
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            sample_en,
    input  logic [1:0]                      class_in,
    input  logic                            flush,
    output logic [NUM_CLASSES-1:0][CW-1:0]  cnt,
    output logic [CW-1:0]                   fill
);

    localparam int PW = $clog2(WINDOW);

    logic [WINDOW-1:0][1:0]         buf_q, buf_d;
    logic [PW-1:0]                  ptr_q, ptr_d;
    logic [CW-1:0]                  fill_q, fill_d;
    logic [NUM_CLASSES-1:0][CW-1:0] cnt_q, cnt_d;
    class_t                         oldest;

    // Next-state of buffer, pointer, fill level and counters
    always_comb begin
        buf_d  = buf_q;
        ptr_d  = ptr_q;
        fill_d = fill_q;
        cnt_d  = cnt_q;
        oldest = buf_q[ptr_q];
        if (flush) begin
            buf_d  = '0;
            ptr_d  = '0;
            fill_d = '0;
            cnt_d  = '0;
        end else if (sample_en) begin
            buf_d[ptr_q] = class_in;
            ptr_d = (ptr_q == PW'(WINDOW - 1)) ? '0 : ptr_q + PW'(1);
            if (fill_q != CW'(WINDOW)) begin
                cnt_d[class_in] = cnt_q[class_in] + CW'(1);
                fill_d          = fill_q + CW'(1);
            end else if (oldest != class_in) begin
                // Full window: the evicted sample hands its vote to the new one
                cnt_d[oldest]   = cnt_q[oldest] - CW'(1);
                cnt_d[class_in] = cnt_q[class_in] + CW'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            buf_d = buf_q;
        end
    end

    // Window state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_q  <= '0;
            ptr_q  <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
        end else begin
            buf_q  <= buf_d;
            ptr_q  <= ptr_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign fill = fill_q;

endmodule

// File: rtl/class_vote_filter.sv
// Debounced, confidence-qualified classification: majority vote over a sliding
// window with a hold-off period after every commit.
module class_vote_filter #(
    parameter int WINDOW  = 8,
    parameter int THRESH  = 6,
    parameter int HOLDOFF = 16
)(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sample_en,
    input  logic [1:0]                    class_in,
    input  logic                          flush,
    output logic [1:0]                    stable_class,
    output logic                          stable_valid,
    output logic                          class_changed,
    output logic [$clog2(WINDOW+1)-1:0]   confidence
);
    import clf_pkg::*;

    localparam int CW = $clog2(WINDOW + 1);
    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    if (WINDOW < 4 || WINDOW > 64 || (WINDOW & (WINDOW - 1)) != 0) begin : g_bad_window
        $error("class_vote_filter: WINDOW must be a power of two in 4..64");
    end
    if (!(THRESH > WINDOW / 2 && THRESH <= WINDOW)) begin : g_bad_thresh
        $error("class_vote_filter: THRESH must satisfy WINDOW/2 < THRESH <= WINDOW");
    end
    if (HOLDOFF < 1) begin : g_bad_holdoff
        $error("class_vote_filter: HOLDOFF must be at least 1");
    end

    logic [NUM_CLASSES-1:0][CW-1:0] cnt;
    logic [CW-1:0]                  fill;
    logic                           win;
    class_t                         wcls;
    logic                           will_be_full;

    vote_state_t   state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    class_t        stable_class_q, stable_class_d;
    logic          stable_valid_q, stable_valid_d;
    logic          class_changed_q, class_changed_d;
    logic [CW-1:0] confidence_q, confidence_d;

    vote_window #(
        .WINDOW (WINDOW)
    ) u_win (
        .clk       (clk),
        .reset     (reset),
        .sample_en (sample_en),
        .class_in  (class_in),
        .flush     (flush),
        .cnt       (cnt),
        .fill      (fill)
    );

    // Winner detection; THRESH above half the window allows at most one hit
    always_comb begin
        win  = 1'b0;
        wcls = 2'd0;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            win  = win | (cnt[c] >= CW'(THRESH));
            wcls = (cnt[c] >= CW'(THRESH)) ? class_t'(c) : wcls;
        end
    end

    // Leaving FILL on the edge that stores the last sample lets TRACK see the full window next cycle
    assign will_be_full = (fill == CW'(WINDOW)) ||
                          ((fill == CW'(WINDOW - 1)) && sample_en);

    // Vote FSM, hold-off counter and commit of the output registers
    always_comb begin
        state_d         = state_q;
        hold_d          = hold_q;
        stable_class_d  = stable_class_q;
        stable_valid_d  = stable_valid_q;
        class_changed_d = 1'b0;
        confidence_d    = confidence_q;
        if (flush) begin
            state_d        = FILL;
            hold_d         = '0;
            stable_valid_d = 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    state_d = will_be_full ? TRACK : FILL;
                end
                TRACK: begin
                    if (win && (!stable_valid_q || (wcls != stable_class_q))) begin
                        stable_class_d  = wcls;
                        stable_valid_d  = 1'b1;
                        class_changed_d = 1'b1;
                        confidence_d    = cnt[wcls];
                        hold_d          = HW'(HOLDOFF - 1);
                        state_d         = HOLD;
                    end else begin
                        state_d = TRACK;
                    end
                end
                HOLD: begin
                    if (hold_q == '0) begin
                        state_d = TRACK;
                    end else begin
                        hold_d = hold_q - HW'(1);
                    end
                end
                default: begin
                    state_d = FILL;
                    hold_d  = '0;
                end
            endcase
        end
    end

    // FSM and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= FILL;
            hold_q          <= '0;
            stable_class_q  <= 2'd0;
            stable_valid_q  <= 1'b0;
            class_changed_q <= 1'b0;
            confidence_q    <= '0;
        end else begin
            state_q         <= state_d;
            hold_q          <= hold_d;
            stable_class_q  <= stable_class_d;
            stable_valid_q  <= stable_valid_d;
            class_changed_q <= class_changed_d;
            confidence_q    <= confidence_d;
        end
    end

    assign stable_class  = stable_class_q;
    assign stable_valid  = stable_valid_q;
    assign class_changed = class_changed_q;
    assign confidence    = confidence_q;

endmodule

// File: tb/tb_class_vote_filter.sv
// Self-checking bench for class_vote_filter: directed scenarios plus random
// traffic against a queue-based majority-vote reference model.
module tb_class_vote_filter;

    localparam int WINDOW  = 8;
    localparam int THRESH  = 6;
    localparam int HOLDOFF = 16;
    localparam int CW      = $clog2(WINDOW + 1);

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          sample_en = 1'b0;
    logic          flush     = 1'b0;
    logic [1:0]    class_in  = 2'd0;
    logic [1:0]    stable_class;
    logic          stable_valid;
    logic          class_changed;
    logic [CW-1:0] confidence;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    class_vote_filter #(
        .WINDOW  (WINDOW),
        .THRESH  (THRESH),
        .HOLDOFF (HOLDOFF)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .sample_en     (sample_en),
        .class_in      (class_in),
        .flush         (flush),
        .stable_class  (stable_class),
        .stable_valid  (stable_valid),
        .class_changed (class_changed),
        .confidence    (confidence)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the window is a plain queue, counts are recounted every edge
    logic [1:0] mq[$];
    int         m_cyc     = 0;
    int         m_last    = -1000;
    logic [1:0] m_class   = 2'd0;
    logic       m_valid   = 1'b0;
    logic       m_changed = 1'b0;
    int         m_conf    = 0;

    task automatic model_step();
        int cnt[4];
        int wc;
        bit w;
        for (int c = 0; c < 4; c++) cnt[c] = 0;
        foreach (mq[i]) cnt[mq[i]]++;
        w  = 1'b0;
        wc = 0;
        for (int c = 0; c < 4; c++) begin
            if (cnt[c] >= THRESH) begin
                w  = 1'b1;
                wc = c;
            end
        end
        m_changed = 1'b0;
        if (!flush && mq.size() == WINDOW && (m_cyc - m_last) > HOLDOFF &&
            w && (!m_valid || wc != int'(m_class))) begin
            m_class   = wc[1:0];
            m_valid   = 1'b1;
            m_conf    = cnt[wc];
            m_changed = 1'b1;
            m_last    = m_cyc;
        end
        if (flush) begin
            mq.delete();
            m_valid = 1'b0;
            m_last  = -1000;
        end else if (sample_en) begin
            mq.push_back(class_in);
            if (mq.size() > WINDOW) void'(mq.pop_front());
        end
        m_cyc++;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_class   = 2'd0;
            m_valid   = 1'b0;
            m_changed = 1'b0;
            m_conf    = 0;
            m_last    = -1000;
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("stable_class",  stable_class,  m_class);
            check("stable_valid",  stable_valid,  m_valid);
            check("class_changed", class_changed, m_changed);
            check("confidence",    confidence,    m_conf);
        end
    end

    task automatic do_sample(input logic [1:0] c);
        sample_en = 1'b1;
        class_in  = c;
        @(negedge clk);
        sample_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic flush_pulse();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    initial begin
        int n;
        int dom;
        repeat (2) @(negedge clk);
        check("rst_class", stable_class, 0);
        check("rst_valid", stable_valid, 0);
        check("rst_pulse", class_changed, 0);
        check("rst_conf",  confidence, 0);
        reset = 1'b0;

        // First fill: 7 samples never commit, the 8th commits two edges later
        for (int i = 0; i < 7; i++) begin
            do_sample(2'd2);
            check("fill_valid", stable_valid, 0);
            check("fill_pulse", class_changed, 0);
        end
        do_sample(2'd2);
        check("t1_pulse_k1", class_changed, 0);
        @(negedge clk);
        check("t1_pulse_k2", class_changed, 1);
        check("t1_class", stable_class, 2);
        check("t1_valid", stable_valid, 1);
        check("t1_conf",  confidence, 8);
        @(negedge clk);
        check("t1_pulse_k3", class_changed, 0);

        // Five votes short of THRESH, the sixth wins
        idle(20);
        for (int i = 0; i < 5; i++) do_sample(2'd1);
        idle(3);
        check("t2_no_change", stable_class, 2);
        do_sample(2'd1);
        check("t2_pulse_k1", class_changed, 0);
        @(negedge clk);
        check("t2_pulse_k2", class_changed, 1);
        check("t2_class", stable_class, 1);
        check("t2_conf",  confidence, 6);

        // New winner right after a commit waits for the hold-off to expire
        for (int i = 0; i < 8; i++) do_sample(2'd3);
        n = 0;
        while (class_changed !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("t3_hold_wait", n, 9);
        check("t3_class", stable_class, 3);
        check("t3_conf",  confidence, 8);

        // Flush with a simultaneous sample while tracking class 1
        idle(20);
        for (int i = 0; i < 8; i++) do_sample(2'd1);
        idle(20);
        check("t5_pre_class", stable_class, 1);
        sample_en = 1'b1;
        class_in  = 2'd2;
        flush     = 1'b1;
        @(negedge clk);
        sample_en = 1'b0;
        flush     = 1'b0;
        check("t5_valid", stable_valid, 0);
        check("t5_class", stable_class, 1);
        check("t5_conf",  confidence, 6);
        check("t5_fill",  u_dut.fill, 0);
        for (int c = 0; c < 4; c++) check("t5_cnt", u_dut.cnt[c], 0);
        for (int i = 0; i < 7; i++) do_sample(2'd1);
        idle(3);
        check("t5_no_commit", stable_valid, 0);
        do_sample(2'd1);
        @(negedge clk);
        check("t5_refill_pulse", class_changed, 1);
        check("t5_refill_conf",  confidence, 8);

        // Alternating classes never reach THRESH
        flush_pulse();
        for (int i = 0; i < 64; i++) do_sample((i % 2 == 0) ? 2'd0 : 2'd1);
        idle(3);
        check("t4_valid", stable_valid, 0);

        // Asynchronous reset in the middle of HOLD
        flush_pulse();
        for (int i = 0; i < 8; i++) do_sample(2'd3);
        @(negedge clk);
        check("t6_commit", stable_class, 3);
        idle(3);
        #2 reset = 1'b1;
        #1;
        check("t6_rst_class", stable_class, 0);
        check("t6_rst_valid", stable_valid, 0);
        check("t6_rst_pulse", class_changed, 0);
        check("t6_rst_conf",  confidence, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) do_sample(2'd0);
        @(negedge clk);
        check("t6_pulse", class_changed, 1);
        check("t6_class", stable_class, 0);
        check("t6_conf",  confidence, 8);

        // Random traffic with a slowly drifting dominant class
        dom = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 59) == 0) dom = $urandom_range(0, 3);
            flush     = ($urandom_range(0, 199) == 0);
            sample_en = ($urandom_range(0, 3) != 0);
            class_in  = ($urandom_range(0, 9) < 8) ? dom[1:0] : 2'($urandom_range(0, 3));
            @(negedge clk);
        end
        sample_en = 1'b0;
        flush     = 1'b0;
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
